// File: rtl/mac_tx_fcs_pad_if.sv
// GMII TX-side bundle between the MAC frame byte generator and the FCS/pad stage.
// master = upstream byte source / observer, slave = the FCS/pad stage itself.
interface mac_tx_fcs_pad_if;
    logic       in_en;
    logic [7:0] in_data;
    logic       out_en;
    logic [7:0] out_data;
    logic       frame_done;
    logic       drop_err;
    logic       abort_err;

    modport master (
        output in_en, in_data,
        input  out_en, out_data, frame_done, drop_err, abort_err
    );

    modport slave (
        input  in_en, in_data,
        output out_en, out_data, frame_done, drop_err, abort_err
    );
endinterface

// File: rtl/mac_tx_fcs_pad.sv
// MAC TX FCS/pad stage: forwards preamble+SFD and the frame body to GMII,
// zero-pads short bodies, appends the CRC-32 FCS and enforces the IFG.
module mac_tx_fcs_pad #(
    parameter int MIN_BODY_LEN = 60,
    parameter int IFG_LEN      = 12,
    parameter int LEN_W        = 11
) (
    input  logic            clk,
    input  logic            RSTn,
    mac_tx_fcs_pad_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_t;

    localparam int               IFG_W    = (IFG_LEN > 1) ? $clog2(IFG_LEN) : 1;
    localparam logic [LEN_W-1:0] MIN_CNT  = LEN_W'(MIN_BODY_LEN);
    localparam logic [LEN_W-1:0] CNT_MAX  = {LEN_W{1'b1}};
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_LEN - 1);
    localparam logic [7:0]       SFD      = 8'hD5;
    localparam logic [31:0]      CRC_POLY = 32'hEDB88320;

    state_t           state, state_next;
    logic [31:0]      crc, crc_next;
    logic [LEN_W-1:0] count, count_next;
    logic [1:0]       byte_idx, byte_idx_next;
    logic [IFG_W-1:0] ifg_cnt, ifg_next;
    logic             out_en_r, out_en_next;
    logic [7:0]       out_data_r, out_data_next;
    logic             frame_done_r, frame_done_next;
    logic             drop_r, drop_next;
    logic             abort_r, abort_next;
    logic             in_en_q;

    logic [31:0]      fcs;
    logic [LEN_W-1:0] count_inc;
    logic             in_rise;
    logic             pad_needed;

    // Reflected CRC-32 over one byte, bit 0 first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign fcs        = ~crc;
    assign count_inc  = (count == CNT_MAX) ? count : count + LEN_W'(1);
    assign in_rise    = bus.in_en & ~in_en_q;
    assign pad_needed = (count < MIN_CNT);

    // State and output registers; reset drops the TX path immediately and re-inits the CRC.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state        <= ST_IDLE;
            crc          <= 32'hFFFFFFFF;
            count        <= '0;
            byte_idx     <= '0;
            ifg_cnt      <= '0;
            out_en_r     <= 1'b0;
            out_data_r   <= 8'h00;
            frame_done_r <= 1'b0;
            drop_r       <= 1'b0;
            abort_r      <= 1'b0;
            in_en_q      <= 1'b0;
        end else begin
            state        <= state_next;
            crc          <= crc_next;
            count        <= count_next;
            byte_idx     <= byte_idx_next;
            ifg_cnt      <= ifg_next;
            out_en_r     <= out_en_next;
            out_data_r   <= out_data_next;
            frame_done_r <= frame_done_next;
            drop_r       <= drop_next;
            abort_r      <= abort_next;
            in_en_q      <= bus.in_en;
        end
    end

    // Frame sequencing; IDLE only accepts a fresh rising in_en so a frame cut by the IFG is never resynced.
    always_comb begin
        state_next      = state;
        crc_next        = crc;
        count_next      = count;
        byte_idx_next   = byte_idx;
        ifg_next        = ifg_cnt;
        out_en_next     = 1'b0;
        out_data_next   = 8'h00;
        frame_done_next = 1'b0;
        drop_next       = 1'b0;
        abort_next      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (in_rise) begin
                    state_next    = ST_PRE;
                    out_en_next   = 1'b1;
                    out_data_next = bus.in_data;
                end
            end
            ST_PRE: begin
                if (!bus.in_en) begin
                    state_next = ST_IDLE;
                    abort_next = 1'b1;
                end else begin
                    out_en_next   = 1'b1;
                    out_data_next = bus.in_data;
                    if (bus.in_data == SFD) begin
                        state_next = ST_DATA;
                        crc_next   = 32'hFFFFFFFF;
                        count_next = '0;
                    end
                end
            end
            ST_DATA: begin
                out_en_next = 1'b1;
                if (bus.in_en) begin
                    out_data_next = bus.in_data;
                    crc_next      = crc_byte(crc, bus.in_data);
                    count_next    = count_inc;
                end else if (pad_needed) begin
                    crc_next   = crc_byte(crc, 8'h00);
                    count_next = count_inc;
                    state_next = ST_PAD;
                end else begin
                    out_data_next = fcs[7:0];
                    byte_idx_next = 2'd1;
                    state_next    = ST_FCS;
                end
            end
            ST_PAD: begin
                out_en_next = 1'b1;
                drop_next   = in_rise;
                if (pad_needed) begin
                    crc_next   = crc_byte(crc, 8'h00);
                    count_next = count_inc;
                end else begin
                    out_data_next = fcs[7:0];
                    byte_idx_next = 2'd1;
                    state_next    = ST_FCS;
                end
            end
            ST_FCS: begin
                out_en_next   = 1'b1;
                drop_next     = in_rise;
                out_data_next = fcs[{byte_idx, 3'b000} +: 8];
                byte_idx_next = byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    frame_done_next = 1'b1;
                    ifg_next        = '0;
                    state_next      = ST_IFG;
                end
            end
            ST_IFG: begin
                drop_next = in_rise;
                if (ifg_cnt == IFG_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    ifg_next = ifg_cnt + IFG_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.out_en     = out_en_r;
    assign bus.out_data   = out_data_r;
    assign bus.frame_done = frame_done_r;
    assign bus.drop_err   = drop_r;
    assign bus.abort_err  = abort_r;

endmodule

// File: tb/tb_mac_tx_fcs_pad.sv
// Self-checking bench for mac_tx_fcs_pad: random frames against a queue-based
// frame model with a bit-serial CRC-32, plus the fixed "123456789" vector.
module tb_mac_tx_fcs_pad;

    logic       clk;
    logic       RSTn;
    logic       in_en;
    logic [7:0] in_data;

    int n_checks;
    int n_fails;
    int cyc = 0;

    mac_tx_fcs_pad_if bus ();
    mac_tx_fcs_pad_if bus9 ();

    assign bus.in_en    = in_en;
    assign bus.in_data  = in_data;
    assign bus9.in_en   = in_en;
    assign bus9.in_data = in_data;

    mac_tx_fcs_pad dut (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (bus)
    );

    mac_tx_fcs_pad #(
        .MIN_BODY_LEN (9),
        .IFG_LEN      (12),
        .LEN_W        (11)
    ) dut9 (
        .clk  (clk),
        .RSTn (RSTn),
        .bus  (bus9)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state, default instance
    logic [7:0] cap_q[$];
    int         run_start[$];
    int         run_len[$];
    int         done_cyc[$];
    int         drop_cnt = 0;
    int         abort_cnt = 0;
    logic       prev_en = 1'b0;
    int         cur_len = 0;

    // Monitor state, MIN_BODY_LEN=9 instance
    logic [7:0] cap9_q[$];
    int         run9_start[$];
    int         run9_len[$];
    int         done9_cyc[$];
    int         drop9_cnt = 0;
    logic       prev9_en = 1'b0;
    int         cur9_len = 0;

    always @(negedge clk) begin
        if (bus.out_en) begin
            cap_q.push_back(bus.out_data);
            if (!prev_en) run_start.push_back(cyc);
            cur_len <= prev_en ? cur_len + 1 : 1;
        end else if (prev_en) begin
            run_len.push_back(cur_len);
        end
        if (bus.frame_done) done_cyc.push_back(cyc);
        if (bus.drop_err) drop_cnt <= drop_cnt + 1;
        if (bus.abort_err) abort_cnt <= abort_cnt + 1;
        prev_en <= bus.out_en;
    end

    always @(negedge clk) begin
        if (bus9.out_en) begin
            cap9_q.push_back(bus9.out_data);
            if (!prev9_en) run9_start.push_back(cyc);
            cur9_len <= prev9_en ? cur9_len + 1 : 1;
        end else if (prev9_en) begin
            run9_len.push_back(cur9_len);
        end
        if (bus9.frame_done) done9_cyc.push_back(cyc);
        if (bus9.drop_err) drop9_cnt <= drop9_cnt + 1;
        prev9_en <= bus9.out_en;
    end

    // Stimulus and reference model state
    logic [7:0] body_q[$];
    logic [7:0] exp_q[$];

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_en   = 1'b0;
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        in_en   = 1'b1;
        in_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_body();
        for (int i = 0; i < 7; i++) drive_byte(8'h55);
        drive_byte(8'hD5);
        foreach (body_q[i]) drive_byte(body_q[i]);
        in_en   = 1'b0;
        in_data = 8'($urandom);
    endtask

    task automatic rand_body(input int len);
        logic [7:0] b;
        body_q.delete();
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 9) == 0) b = 8'hD5;
            body_q.push_back(b);
        end
    endtask

    // Expected wire image of one frame: preamble, SFD, body, zero pad, FCS LSB byte first.
    task automatic add_expected(input int min_len);
        logic [7:0]  msg[$];
        logic [31:0] c;
        logic        fb;
        msg = body_q;
        while (msg.size() < min_len) msg.push_back(8'h00);
        c = 32'hFFFFFFFF;
        foreach (msg[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ msg[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        c = ~c;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (msg[i]) exp_q.push_back(msg[i]);
        for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
    endtask

    task automatic apply_reset();
        RSTn  = 1'b0;
        idle(2);
        RSTn  = 1'b1;
        idle(2);
    endtask

    task automatic test_reset();
        RSTn    = 1'b0;
        in_en   = 1'b1;
        in_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (bus.out_en !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_out_en: got %b, want 0", bus.out_en);
        end
        n_checks++;
        if (bus.out_data !== 8'h00) begin
            n_fails++;
            $display("[TB] FAIL reset_out_data: got %h, want 00", bus.out_data);
        end
        n_checks++;
        if ({bus.frame_done, bus.drop_err, bus.abort_err} !== 3'b000) begin
            n_fails++;
            $display("[TB] FAIL reset_pulses: got %b, want 000", {bus.frame_done, bus.drop_err, bus.abort_err});
        end
        n_checks++;
        if (bus9.out_en !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL reset_out_en_9: got %b, want 0", bus9.out_en);
        end
        idle(2);
        RSTn = 1'b1;
        idle(3);
        n_checks++;
        if (bus.out_en !== 1'b0) begin
            n_fails++;
            $display("[TB] FAIL idle_after_reset: out_en got %b, want 0", bus.out_en);
        end
    endtask

    task automatic test_known_vector();
        int          c0, r0, d0, dr0, nbad, first;
        logic [31:0] got_fcs;
        apply_reset();
        c0 = cap9_q.size(); r0 = run9_start.size(); d0 = done9_cyc.size(); dr0 = drop9_cnt;
        exp_q.delete();
        body_q.delete();
        for (int i = 0; i < 9; i++) body_q.push_back(8'h31 + 8'(i));
        add_expected(9);
        send_body();
        idle(16);
        rand_body(12);
        add_expected(9);
        send_body();
        idle(15);
        rand_body(10);
        send_body();
        idle(40);

        nbad = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (c0 + i >= cap9_q.size() || cap9_q[c0+i] !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (nbad != 0 || cap9_q.size() - c0 != exp_q.size()) begin
            n_fails++;
            $display("[TB] FAIL vec_bytes: got %0d bytes (%0d wrong, first %0d), want %0d bytes",
                     cap9_q.size() - c0, nbad, first, exp_q.size());
        end
        got_fcs = 32'h0;
        if (cap9_q.size() >= c0 + 21)
            got_fcs = {cap9_q[c0+20], cap9_q[c0+19], cap9_q[c0+18], cap9_q[c0+17]};
        n_checks++;
        if (got_fcs !== 32'hCBF43926) begin
            n_fails++;
            $display("[TB] FAIL vec_fcs: got %h, want cbf43926", got_fcs);
        end
        n_checks++;
        if (run9_len.size() - r0 != 2 || done9_cyc.size() - d0 != 2) begin
            n_fails++;
            $display("[TB] FAIL vec_frames: got %0d runs %0d done, want 2 and 2",
                     run9_len.size() - r0, done9_cyc.size() - d0);
        end else begin
            n_checks++;
            if (run9_len[r0] != 21) begin
                n_fails++;
                $display("[TB] FAIL vec_run_len: got %0d, want 21", run9_len[r0]);
            end
            n_checks++;
            if (done9_cyc[d0] != run9_start[r0] + 20) begin
                n_fails++;
                $display("[TB] FAIL vec_done_pos: got cycle %0d, want %0d", done9_cyc[d0], run9_start[r0] + 20);
            end
            n_checks++;
            if (run9_start[r0+1] - done9_cyc[d0] != 13) begin
                n_fails++;
                $display("[TB] FAIL vec_ifg: got %0d idle cycles, want 12", run9_start[r0+1] - done9_cyc[d0] - 1);
            end
        end
        n_checks++;
        if (drop9_cnt - dr0 != 1) begin
            n_fails++;
            $display("[TB] FAIL vec_drop_boundary: got %0d drop pulses, want 1", drop9_cnt - dr0);
        end
    endtask

    // Runs a list of body lengths through the default instance with generous gaps.
    task automatic run_lengths(input string name, input int l0, input int l1, input int l2);
        int lens[3];
        int c0, r0, d0, nbad, first, want;
        lens[0] = l0; lens[1] = l1; lens[2] = l2;
        apply_reset();
        c0 = cap_q.size(); r0 = run_start.size(); d0 = done_cyc.size();
        exp_q.delete();
        for (int f = 0; f < 3; f++) begin
            rand_body(lens[f]);
            add_expected(60);
            send_body();
            idle(90);
        end
        nbad = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (c0 + i >= cap_q.size() || cap_q[c0+i] !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (nbad != 0 || cap_q.size() - c0 != exp_q.size()) begin
            n_fails++;
            $display("[TB] FAIL %s_bytes: got %0d bytes (%0d wrong, first %0d), want %0d bytes",
                     name, cap_q.size() - c0, nbad, first, exp_q.size());
        end
        n_checks++;
        if (run_len.size() - r0 != 3 || done_cyc.size() - d0 != 3) begin
            n_fails++;
            $display("[TB] FAIL %s_frames: got %0d runs %0d done, want 3 and 3",
                     name, run_len.size() - r0, done_cyc.size() - d0);
        end else begin
            for (int f = 0; f < 3; f++) begin
                want = 8 + ((lens[f] < 60) ? 60 : lens[f]) + 4;
                n_checks++;
                if (run_len[r0+f] != want || done_cyc[d0+f] != run_start[r0+f] + want - 1) begin
                    n_fails++;
                    $display("[TB] FAIL %s_len%0d: got run %0d done at +%0d, want run %0d done at +%0d",
                             name, lens[f], run_len[r0+f], done_cyc[d0+f] - run_start[r0+f], want, want - 1);
                end
            end
        end
    endtask

    task automatic test_pad();
        run_lengths("pad", 42, 59, int'($urandom_range(1, 58)));
    endtask

    task automatic test_no_pad();
        run_lengths("nopad", 100, 60, int'($urandom_range(61, 300)));
    endtask

    task automatic test_abort();
        int c0, r0, d0, a0, nbad, first;
        apply_reset();
        c0 = cap_q.size(); r0 = run_start.size(); d0 = done_cyc.size(); a0 = abort_cnt;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive_byte(8'h55);
            exp_q.push_back(8'h55);
        end
        idle(1);
        rand_body(int'($urandom_range(60, 90)));
        add_expected(60);
        send_body();
        idle(40);
        n_checks++;
        if (abort_cnt - a0 != 1) begin
            n_fails++;
            $display("[TB] FAIL abort_pulse: got %0d, want 1", abort_cnt - a0);
        end
        nbad = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (c0 + i >= cap_q.size() || cap_q[c0+i] !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (nbad != 0 || cap_q.size() - c0 != exp_q.size()) begin
            n_fails++;
            $display("[TB] FAIL abort_bytes: got %0d bytes (%0d wrong, first %0d), want %0d bytes",
                     cap_q.size() - c0, nbad, first, exp_q.size());
        end
        n_checks++;
        if (run_len.size() - r0 != 2 || done_cyc.size() - d0 != 1) begin
            n_fails++;
            $display("[TB] FAIL abort_frames: got %0d runs %0d done, want 2 and 1",
                     run_len.size() - r0, done_cyc.size() - d0);
        end else begin
            n_checks++;
            if (run_len[r0] != 3 || run_start[r0+1] != run_start[r0] + 4) begin
                n_fails++;
                $display("[TB] FAIL abort_timing: got run %0d next start +%0d, want run 3 next start +4",
                         run_len[r0], run_start[r0+1] - run_start[r0]);
            end
        end
    endtask

    task automatic test_ifg_drop();
        int c0, r0, d0, dr0, nbad, first;
        apply_reset();
        c0 = cap_q.size(); r0 = run_start.size(); d0 = done_cyc.size(); dr0 = drop_cnt;
        exp_q.delete();
        rand_body(64);
        add_expected(60);
        send_body();
        idle(8);
        rand_body(30);
        send_body();
        idle(40);
        rand_body(50);
        add_expected(60);
        send_body();
        idle(90);
        n_checks++;
        if (drop_cnt - dr0 != 1) begin
            n_fails++;
            $display("[TB] FAIL ifg_drop_pulse: got %0d, want 1", drop_cnt - dr0);
        end
        nbad = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (c0 + i >= cap_q.size() || cap_q[c0+i] !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (nbad != 0 || cap_q.size() - c0 != exp_q.size()) begin
            n_fails++;
            $display("[TB] FAIL ifg_drop_bytes: got %0d bytes (%0d wrong, first %0d), want %0d bytes",
                     cap_q.size() - c0, nbad, first, exp_q.size());
        end
        n_checks++;
        if (run_len.size() - r0 != 2 || done_cyc.size() - d0 != 2) begin
            n_fails++;
            $display("[TB] FAIL ifg_drop_frames: got %0d runs %0d done, want 2 and 2",
                     run_len.size() - r0, done_cyc.size() - d0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0, d0, nbad, first;
        apply_reset();
        d0 = done_cyc.size();
        exp_q.delete();
        rand_body(70);
        add_expected(60);
        send_body();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_en !== 1'b1 || bus.out_data !== exp_q[exp_q.size()-3]) begin
            n_fails++;
            $display("[TB] FAIL mid_fcs_byte1: got en %b data %h, want en 1 data %h",
                     bus.out_en, bus.out_data, exp_q[exp_q.size()-3]);
        end
        #1;
        RSTn = 1'b0;
        #1;
        n_checks++;
        if (bus.out_en !== 1'b0 || bus.out_data !== 8'h00) begin
            n_fails++;
            $display("[TB] FAIL mid_reset_async: got en %b data %h, want en 0 data 00", bus.out_en, bus.out_data);
        end
        idle(3);
        RSTn = 1'b1;
        idle(2);
        n_checks++;
        if (done_cyc.size() != d0) begin
            n_fails++;
            $display("[TB] FAIL mid_reset_done: got %0d frame_done pulses, want 0", done_cyc.size() - d0);
        end
        c0 = cap_q.size();
        exp_q.delete();
        rand_body(65);
        add_expected(60);
        send_body();
        idle(40);
        nbad = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (c0 + i >= cap_q.size() || cap_q[c0+i] !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (nbad != 0 || cap_q.size() - c0 != exp_q.size()) begin
            n_fails++;
            $display("[TB] FAIL mid_reset_next: got %0d bytes (%0d wrong, first %0d), want %0d bytes",
                     cap_q.size() - c0, nbad, first, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int c0, r0, d0, dr0, nbad, first, len, pad;
        apply_reset();
        c0 = cap_q.size(); r0 = run_start.size(); d0 = done_cyc.size(); dr0 = drop_cnt;
        exp_q.delete();
        for (int f = 0; f < 5; f++) begin
            len = int'($urandom_range(1, 150));
            pad = (len < 60) ? 60 - len : 0;
            rand_body(len);
            add_expected(60);
            send_body();
            idle((f == 4) ? 40 + pad : 16 + pad);
        end
        nbad = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (c0 + i >= cap_q.size() || cap_q[c0+i] !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (nbad != 0 || cap_q.size() - c0 != exp_q.size()) begin
            n_fails++;
            $display("[TB] FAIL b2b_bytes: got %0d bytes (%0d wrong, first %0d), want %0d bytes",
                     cap_q.size() - c0, nbad, first, exp_q.size());
        end
        n_checks++;
        if (drop_cnt != dr0) begin
            n_fails++;
            $display("[TB] FAIL b2b_drop: got %0d drop pulses, want 0", drop_cnt - dr0);
        end
        n_checks++;
        if (run_len.size() - r0 != 5 || done_cyc.size() - d0 != 5) begin
            n_fails++;
            $display("[TB] FAIL b2b_frames: got %0d runs %0d done, want 5 and 5",
                     run_len.size() - r0, done_cyc.size() - d0);
        end else begin
            for (int f = 0; f < 4; f++) begin
                n_checks++;
                if (run_start[r0+f+1] - done_cyc[d0+f] != 13) begin
                    n_fails++;
                    $display("[TB] FAIL b2b_gap%0d: got %0d idle cycles, want 12",
                             f, run_start[r0+f+1] - done_cyc[d0+f] - 1);
                end
            end
        end
    endtask

    task automatic test_long_frame();
        int c0, r0, nbad, first;
        apply_reset();
        c0 = cap_q.size(); r0 = run_start.size();
        exp_q.delete();
        rand_body(2100);
        add_expected(60);
        send_body();
        idle(40);
        nbad = 0; first = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (c0 + i >= cap_q.size() || cap_q[c0+i] !== exp_q[i]) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (nbad != 0 || cap_q.size() - c0 != exp_q.size()) begin
            n_fails++;
            $display("[TB] FAIL long_bytes: got %0d bytes (%0d wrong, first %0d), want %0d bytes",
                     cap_q.size() - c0, nbad, first, exp_q.size());
        end
        n_checks++;
        if (run_len.size() - r0 != 1 || (run_len.size() > r0 && run_len[r0] != 2112)) begin
            n_fails++;
            $display("[TB] FAIL long_run: got %0d runs, want one run of 2112", run_len.size() - r0);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fails  = 0;
        RSTn     = 1'b0;
        in_en    = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_known_vector();
        test_pad();
        test_no_pad();
        test_abort();
        test_ifg_drop();
        test_reset_mid_frame();
        test_back_to_back();
        test_long_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
